// File: rtl/audio_pkg.sv
// Shared types and defaults for the FT2232 sync-FIFO audio loopback path.
package audio_pkg;
   // Bus phase of the FT2232 245-style synchronous FIFO interface
   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RD_OE = 2'd1,
      RD    = 2'd2,
      WR    = 2'd3
   } state_t;

   localparam int FIFO_DEPTH_DEF   = 16;
   localparam int LED_DIV_BITS_DEF = 8;

   // FT2232 strobes are active-low; this is their idle level
   localparam logic STROBE_OFF = 1'b1;
endpackage

// File: rtl/byte_fifo.sv
// Synchronous show-ahead byte FIFO: head is the oldest byte, visible without a pop.
module byte_fifo
   import audio_pkg::*;
#(
   parameter  int DEPTH = FIFO_DEPTH_DEF,
   localparam int AW    = $clog2(DEPTH)
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          push,
   input  logic          pop,
   input  logic [7:0]    din,
   output logic [7:0]    head,
   output logic [AW:0]   count,
   output logic          empty,
   output logic          full
);
   logic [7:0]    mem [DEPTH];
   logic [AW-1:0] wr_ptr;
   logic [AW-1:0] rd_ptr;
   logic          do_push;
   logic          do_pop;

   assign do_push = push & ~full;
   assign do_pop  = pop & ~empty;
   assign empty   = (count == '0);
   assign full    = (count == (AW+1)'(DEPTH));
   assign head    = mem[rd_ptr];

   // Storage needs no reset; contents are meaningless while count is zero
   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr] <= din;
   end

   // Pointers and occupancy; reset discards everything buffered
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + AW'(1);
         if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
         count <= count + (AW+1)'(do_push) - (AW+1)'(do_pop);
      end
   end
endmodule

// File: rtl/audio_top.sv
// FT2232 channel A sync-FIFO loopback: read bytes from host, buffer, write them back.
module audio_top
   import audio_pkg::*;
#(
   parameter int FIFO_DEPTH   = FIFO_DEPTH_DEF,
   parameter int LED_DIV_BITS = LED_DIV_BITS_DEF
) (
   input  logic       fifo_clk,
   input  logic       btn_reset,
   input  logic       fifo_txe_n,
   input  logic       fifo_rxf_n,
   output logic       ft2232_reset_n,
   output logic       fifo_oe_n,
   output logic       fifo_siwu,
   output logic       fifo_wr_n,
   output logic       fifo_rd_n,
   inout  wire  [7:0] fifo_data,
   output logic       led_0,
   output logic       led_1,
   output logic       led_reset,
   output logic       led_user
);
   localparam int CW = $clog2(FIFO_DEPTH) + 1;
   // Stop reading with two slots of headroom left in the buffer
   localparam logic [CW-1:0] RD_LIMIT = CW'(FIFO_DEPTH - 2);

   state_t                  state;
   state_t                  state_nx;
   logic [7:0]              head;
   logic [CW-1:0]           count;
   logic [CW-1:0]           count_nx;
   logic                    empty;
   logic                    full;
   logic                    push;
   logic                    pop;
   logic [LED_DIV_BITS-1:0] rx_cnt;
   logic [LED_DIV_BITS-1:0] tx_cnt;

   assign ft2232_reset_n = ~btn_reset;
   assign led_reset      = btn_reset;

   // A byte moves only when our strobe and the host's ready flag are both low
   assign push     = ~fifo_rd_n & ~fifo_rxf_n;
   assign pop      = ~fifo_wr_n & ~fifo_txe_n;
   assign count_nx = count + CW'(push) - CW'(pop);

   // Only WR drives the bus; oe_n is high in WR, so no contention with the FT2232
   assign fifo_data = (state == WR) ? head : 8'hzz;

   byte_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
      .clk   (fifo_clk),
      .rst   (btn_reset),
      .push  (push),
      .pop   (pop),
      .din   (fifo_data),
      .head  (head),
      .count (count),
      .empty (empty),
      .full  (full)
   );

   // Next bus phase: draining the buffer to the host wins over reading more
   always_comb begin
      state_nx = state;
      case (state)
         IDLE: begin
            if (!empty && !fifo_txe_n)
               state_nx = WR;
            else if (!fifo_rxf_n && count < RD_LIMIT)
               state_nx = RD_OE;
         end
         RD_OE:   state_nx = RD;
         RD:      if (fifo_rxf_n || count_nx >= RD_LIMIT) state_nx = IDLE;
         WR:      if (fifo_txe_n || count_nx == '0) state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end

   // State and registered strobes, decoded from the phase being entered
   always_ff @(posedge fifo_clk or posedge btn_reset) begin
      if (btn_reset) begin
         state     <= IDLE;
         fifo_oe_n <= STROBE_OFF;
         fifo_rd_n <= STROBE_OFF;
         fifo_wr_n <= STROBE_OFF;
         fifo_siwu <= STROBE_OFF;
      end else begin
         state     <= state_nx;
         fifo_oe_n <= ~((state_nx == RD_OE) || (state_nx == RD));
         fifo_rd_n <= ~(state_nx == RD);
         fifo_wr_n <= ~(state_nx == WR);
         fifo_siwu <= STROBE_OFF;
      end
   end

   // Activity LEDs: toggle once per 2^LED_DIV_BITS bytes each way
   always_ff @(posedge fifo_clk or posedge btn_reset) begin
      if (btn_reset) begin
         rx_cnt   <= '0;
         tx_cnt   <= '0;
         led_0    <= 1'b0;
         led_1    <= 1'b0;
         led_user <= 1'b0;
      end else begin
         if (push) begin
            rx_cnt <= rx_cnt + 1'b1;
            if (&rx_cnt) led_0 <= ~led_0;
         end
         if (pop) begin
            tx_cnt <= tx_cnt + 1'b1;
            if (&tx_cnt) led_1 <= ~led_1;
         end
         led_user <= (count_nx != '0);
      end
   end

   // Read phase must end before the buffer can fill
   a_no_overflow: assert property (@(posedge fifo_clk) disable iff (btn_reset) !(push && full));
endmodule

// File: tb/tb_audio_top.sv
// Randomized loopback bench with a queue-based host and buffer model.
module tb_audio_top;
   localparam int DEPTH = 16;
   localparam int LDB   = 8;

   logic fifo_clk = 1'b0;
   logic btn_reset = 1'b0;
   logic fifo_txe_n = 1'b1;
   logic fifo_rxf_n = 1'b1;
   logic ft2232_reset_n, fifo_oe_n, fifo_siwu, fifo_wr_n, fifo_rd_n;
   logic led_0, led_1, led_reset, led_user;
   wire  [7:0] fifo_data;
   logic [7:0] host_byte = 8'h00;

   // Host drives the bus whenever the FPGA asks it to
   assign fifo_data = fifo_oe_n ? 8'hzz : host_byte;

   audio_top dut (
      .fifo_clk       (fifo_clk),
      .btn_reset      (btn_reset),
      .fifo_txe_n     (fifo_txe_n),
      .fifo_rxf_n     (fifo_rxf_n),
      .ft2232_reset_n (ft2232_reset_n),
      .fifo_oe_n      (fifo_oe_n),
      .fifo_siwu      (fifo_siwu),
      .fifo_wr_n      (fifo_wr_n),
      .fifo_rd_n      (fifo_rd_n),
      .fifo_data      (fifo_data),
      .led_0          (led_0),
      .led_1          (led_1),
      .led_reset      (led_reset),
      .led_user       (led_user)
   );

   initial forever #5 fifo_clk = ~fifo_clk;

   int nvec = 0;
   int nerr = 0;
   int rx_mode = 2;  // 0 offer when data, 1 random gaps, 2 never
   int tx_mode = 1;  // 0 always ready, 1 blocked, 2 random
   int rx_total = 0;
   int tx_total = 0;
   logic prev_oe_n = 1'b1;
   logic [7:0] src_q[$];
   logic [7:0] mdl_q[$];
   logic [7:0] got_q[$];
   logic [7:0] exp_q[$];

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      nvec++;
      if (act !== exp) begin
         nerr++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   task automatic cyc(input int n);
      repeat (n) @(posedge fifo_clk);
      #2;
   endtask

   task automatic wait_got(input int n, input int bound, input string nm);
      for (int i = 0; i < bound && got_q.size() < n; i++) cyc(1);
      chk(nm, got_q.size(), n);
   endtask

   task automatic clear_model();
      src_q.delete(); mdl_q.delete(); got_q.delete();
      rx_total = 0; tx_total = 0; prev_oe_n = 1'b1;
   endtask

   // Host + reference model: decide inputs for the coming edge, then account for
   // every handshake that edge will perform
   initial forever begin
      @(negedge fifo_clk);
      if (!btn_reset) begin
         chk("siwu", fifo_siwu, 1);
         chk("led_user", led_user, mdl_q.size() != 0);
         chk("led_0", led_0, (rx_total >> LDB) & 1);
         chk("led_1", led_1, (tx_total >> LDB) & 1);
         chk("bus_excl", {fifo_oe_n, fifo_wr_n} != 2'b00, 1);
         if (!fifo_rd_n) chk("oe_before_rd", {fifo_oe_n, prev_oe_n}, 0);
         if (!fifo_oe_n && prev_oe_n) chk("turnaround", fifo_rd_n, 1);
         case (rx_mode)
            0:       fifo_rxf_n = (src_q.size() == 0);
            1:       fifo_rxf_n = (src_q.size() == 0) || ($urandom_range(0, 3) == 0);
            default: fifo_rxf_n = 1'b1;
         endcase
         case (tx_mode)
            0:       fifo_txe_n = 1'b0;
            1:       fifo_txe_n = 1'b1;
            default: fifo_txe_n = ($urandom_range(0, 2) == 0);
         endcase
         host_byte = (src_q.size() != 0) ? src_q[0] : 8'h00;
         if (!fifo_rd_n && !fifo_rxf_n) begin
            mdl_q.push_back(src_q[0]);
            void'(src_q.pop_front());
            rx_total++;
            chk("headroom", mdl_q.size() <= DEPTH - 2, 1);
         end
         if (!fifo_wr_n && !fifo_txe_n) begin
            chk("wr_nonempty", mdl_q.size() != 0, 1);
            if (mdl_q.size() != 0) begin
               chk("wr_data", fifo_data, mdl_q[0]);
               got_q.push_back(fifo_data);
               void'(mdl_q.pop_front());
            end
            tx_total++;
         end
         prev_oe_n = fifo_oe_n;
      end
   end

   initial begin
      int rx0;
      // Reset
      #1 btn_reset = 1'b1;
      #1;
      chk("rst_ft_n", ft2232_reset_n, 0);
      chk("rst_led", led_reset, 1);
      cyc(2);
      chk("rst_oe", fifo_oe_n, 1);
      chk("rst_rd", fifo_rd_n, 1);
      chk("rst_wr", fifo_wr_n, 1);
      chk("rst_siwu", fifo_siwu, 1);
      chk("rst_leds", {led_0, led_1, led_user}, 3'b000);
      btn_reset = 1'b0;
      rx_mode = 2; tx_mode = 0;
      cyc(5);
      chk("idle_ft_n", ft2232_reset_n, 1);
      chk("idle_led", led_reset, 0);
      chk("idle_strobes", {fifo_oe_n, fifo_rd_n, fifo_wr_n}, 3'b111);

      // Loopback of four bytes
      src_q = '{8'h11, 8'h12, 8'h13, 8'h14};
      rx_mode = 0;
      wait_got(4, 200, "loop_done");
      for (int i = 0; i < 4; i++) chk("loop_byte", got_q[i], 8'h11 + i);
      cyc(3);
      chk("loop_led_user", led_user, 0);

      // Backpressure: only the headroom limit is accepted
      tx_mode = 1; got_q.delete(); rx0 = rx_total;
      for (int i = 0; i < 20; i++) src_q.push_back(8'h30 + 8'(i));
      cyc(60);
      chk("bp_accepted", rx_total - rx0, 14);
      chk("bp_left", src_q.size(), 6);
      chk("bp_strobes", {fifo_oe_n, fifo_rd_n}, 2'b11);
      rx_mode = 2; src_q.delete(); tx_mode = 0;
      wait_got(14, 200, "bp_drain");
      for (int i = 0; i < 14; i++) chk("bp_byte", got_q[i], 8'h30 + i);

      // Write stall mid-stream
      got_q.delete();
      for (int i = 0; i < 8; i++) src_q.push_back(8'hA0 + 8'(i));
      rx_mode = 0; tx_mode = 0;
      for (int i = 0; i < 200 && got_q.size() < 3; i++) cyc(1);
      tx_mode = 1; cyc(3); tx_mode = 0;
      wait_got(8, 300, "stall_done");
      for (int i = 0; i < 8; i++) chk("stall_byte", got_q[i], 8'hA0 + i);

      // Random traffic on both sides
      got_q.delete(); exp_q.delete();
      for (int i = 0; i < 200; i++) begin
         src_q.push_back(8'($urandom));
         exp_q.push_back(src_q[i]);
      end
      rx_mode = 1; tx_mode = 2;
      wait_got(200, 6000, "rand_done");
      for (int i = 0; i < 200; i++) chk("rand_byte", got_q[i], exp_q[i]);

      // Reset during a read burst
      rx_mode = 0; tx_mode = 1;
      for (int i = 0; i < 10; i++) src_q.push_back(8'h50 + 8'(i));
      for (int i = 0; i < 100 && fifo_rd_n; i++) cyc(1);
      chk("mid_in_rd", fifo_rd_n, 0);
      cyc(2);
      btn_reset = 1'b1;
      clear_model();
      #1;
      chk("mid_strobes", {fifo_oe_n, fifo_rd_n, fifo_wr_n}, 3'b111);
      chk("mid_led_user", led_user, 0);
      cyc(2);
      btn_reset = 1'b0;
      tx_mode = 0;
      cyc(10);
      chk("mid_no_tx", tx_total, 0);
      chk("mid_empty", led_user, 0);

      // LED divider over 256 bytes
      for (int i = 0; i < 256; i++) src_q.push_back(8'(i));
      wait_got(256, 4000, "led_done");
      chk("led_rx_total", rx_total, 256);
      chk("led_0_toggled", led_0, 1);
      chk("led_1_toggled", led_1, 1);

      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end
endmodule
